// File: rtl/dadda_cpa_stage.sv
// Final carry-propagate adder of the DADDA multiplier: two-stage pipeline split at bit W.
// Optional DADDA_CPA_STATUS_EN adds registered prod_zero / prod_hi_nz status outputs.
module dadda_cpa_stage #(
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] row_s,
  input  logic [2*W-1:0] row_c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic [7:0]     prod_count
`ifdef DADDA_CPA_STATUS_EN
  ,
  output logic           prod_zero,
  output logic           prod_hi_nz
`endif
);

  logic           s1_valid_r;
  logic [W-1:0]   lo_sum_r;
  logic           lo_carry_r;
  logic [W-1:0]   hi_s_r;
  logic [W-1:0]   hi_c_r;
  logic           out_valid_r;
  logic [2*W-1:0] product_r;
  logic [7:0]     prod_count_r;

  logic           advance_s;
  logic           in_ready_s;
  logic           s1_load_s;
  logic           s2_load_s;
  logic [W:0]     lo_add_s;
  logic [W-1:0]   hi_add_s;
  logic [2*W-1:0] product_next_s;

  // Handshake control and the two half-width additions.
  always_comb begin
    advance_s      = !out_valid_r || out_ready;
    in_ready_s     = !s1_valid_r || advance_s;
    s1_load_s      = in_valid && in_ready_s;
    s2_load_s      = s1_valid_r && advance_s;
    lo_add_s       = {1'b0, row_s[W-1:0]} + {1'b0, row_c[W-1:0]};
    // Carry out of the top bit is dropped: the product is modulo 2^(2W).
    hi_add_s       = hi_s_r + hi_c_r + {{(W-1){1'b0}}, lo_carry_r};
    product_next_s = {hi_add_s, lo_sum_r};
  end

  // Stage 1: low-half sum with its carry, plus the untouched high halves.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_valid_r <= 1'b0;
      lo_sum_r   <= {W{1'b0}};
      lo_carry_r <= 1'b0;
      hi_s_r     <= {W{1'b0}};
      hi_c_r     <= {W{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      lo_sum_r   <= lo_add_s[W-1:0];
      lo_carry_r <= lo_add_s[W];
      hi_s_r     <= row_s[2*W-1:W];
      hi_c_r     <= row_c[2*W-1:W];
    end else if (advance_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: output register; holds while the consumer stalls.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid_r <= 1'b0;
      product_r   <= {(2*W){1'b0}};
    end else if (s2_load_s) begin
      out_valid_r <= 1'b1;
      product_r   <= product_next_s;
    end else if (advance_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Count of products taken by the consumer; wraps naturally at 8 bits.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prod_count_r <= 8'd0;
    end else if (out_valid_r && out_ready) begin
      prod_count_r <= prod_count_r + 8'd1;
    end else begin
      prod_count_r <= prod_count_r;
    end
  end

`ifdef DADDA_CPA_STATUS_EN
  logic prod_zero_r;
  logic prod_hi_nz_r;

  // Status flags computed from the next product so they align with it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prod_zero_r  <= 1'b0;
      prod_hi_nz_r <= 1'b0;
    end else if (s2_load_s) begin
      prod_zero_r  <= (product_next_s == {(2*W){1'b0}});
      prod_hi_nz_r <= |product_next_s[2*W-1:W];
    end else begin
      prod_zero_r  <= prod_zero_r;
      prod_hi_nz_r <= prod_hi_nz_r;
    end
  end

  assign prod_zero  = prod_zero_r;
  assign prod_hi_nz = prod_hi_nz_r;
`endif

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign product    = product_r;
  assign prod_count = prod_count_r;

endmodule

// File: tb/tb_dadda_cpa_stage.sv
// Self-checking bench for dadda_cpa_stage: directed steps with a scoreboard queue.
// Status outputs are checked when DADDA_CPA_STATUS_EN is defined.
module tb_dadda_cpa_stage;
  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] row_s;
  logic [2*W-1:0] row_c;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic [7:0]     prod_count;
`ifdef DADDA_CPA_STATUS_EN
  logic           prod_zero;
  logic           prod_hi_nz;
`endif

  dadda_cpa_stage #(.W(W)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .row_s(row_s),
    .row_c(row_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product(product),
    .prod_count(prod_count)
`ifdef DADDA_CPA_STATUS_EN
    ,
    .prod_zero(prod_zero),
    .prod_hi_nz(prod_hi_nz)
`endif
  );

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int fail_cnt = 0;
  logic [2*W-1:0] exp_q[$];
  logic [7:0]     cnt_exp = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, sample just after, score handshakes of the coming edge.
  task automatic step(input logic v, input logic [2*W-1:0] s, input logic [2*W-1:0] c,
                      input logic r, output logic acc);
    logic [2*W-1:0] e;
    @(negedge CLK);
    in_valid  = v;
    row_s     = s;
    row_c     = c;
    out_ready = r;
    #1;
    acc = v && in_ready;
    chk("prod_count", {24'd0, prod_count}, {24'd0, cnt_exp});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("product", {16'd0, product}, {16'd0, e});
`ifdef DADDA_CPA_STATUS_EN
        chk("prod_zero", {31'd0, prod_zero}, {31'd0, (e == 16'd0)});
        chk("prod_hi_nz", {31'd0, prod_hi_nz}, {31'd0, (|e[15:8])});
`endif
        cnt_exp = cnt_exp + 8'd1;
      end
    end
    if (acc) begin
      exp_q.push_back(s + c);
    end
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    do begin
      step(1'b0, 16'd0, 16'd0, 1'b1, acc);
      n++;
    end while ((exp_q.size() > 0 || out_valid) && n < 12);
    chk("drain_done", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic acc;
    logic [2*W-1:0] ps, pc, held;
    logic [7:0] base;
    int nacc;

    RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b0; row_s = 16'd0; row_c = 16'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    chk("rst_prod_count", {24'd0, prod_count}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Carry across the split, with explicit latency check.
    step(1'b1, 16'h00FF, 16'h0001, 1'b1, acc);
    chk("first_accept", {31'd0, acc}, 32'd1);
    step(1'b0, 16'd0, 16'd0, 1'b1, acc);
    chk("latency_not_early", {31'd0, out_valid}, 32'd0);
    step(1'b0, 16'd0, 16'd0, 1'b1, acc);
    chk("latency_two_edges", {31'd0, out_valid}, 32'd1);
    drain();

    // Wrap-around and full-range rows.
    step(1'b1, 16'hFFFF, 16'h0001, 1'b1, acc);
    step(1'b1, 16'h7E01, 16'h8000, 1'b1, acc);
`ifdef DADDA_CPA_STATUS_EN
    step(1'b1, 16'h0000, 16'h0000, 1'b1, acc);
`endif
    drain();
    chk("wrap_count", {24'd0, prod_count}, {24'd0, cnt_exp});

    // Back-to-back random stream.
    base = prod_count;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'b1, acc);
      chk("stream_in_ready", {31'd0, acc}, 32'd1);
    end
    drain();
    chk("stream_count", {24'd0, prod_count - base}, 32'd20);

    // Backpressure: only two items fit, output holds steady.
    nacc = 0;
    ps = 16'($urandom); pc = 16'($urandom);
    held = 16'd0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ps, pc, 1'b0, acc);
      if (i >= 3) chk("bp_stable", {16'd0, product}, {16'd0, held});
      held = product;
      if (acc) begin
        nacc++;
        ps = 16'($urandom); pc = 16'($urandom);
      end
    end
    chk("bp_accepted", nacc, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // Asynchronous reset with two items in flight.
    step(1'b1, 16'h1234, 16'h4321, 1'b1, acc);
    step(1'b1, 16'h0F0F, 16'hF0F0, 1'b1, acc);
    @(negedge CLK);
    in_valid = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_product", {16'd0, product}, 32'd0);
    chk("async_prod_count", {24'd0, prod_count}, 32'd0);
    exp_q.delete();
    cnt_exp = 8'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'd0, 16'd0, 1'b1, acc);
      chk("post_reset_idle", {31'd0, out_valid}, 32'd0);
    end
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dadda_cpa_stage.md
Name: dadda_cpa_stage

Overview:
- Final carry-propagate stage of the DADDA multiplier.
- Consumes the two-row output (sum row, carry row) of the half/full-adder reduction tree and produces the registered 2W-bit product.
- Two-stage pipelined adder split at bit W. The low half is added in stage 1 and the high half in stage 2 with the registered carry.
- Valid/ready handshake on both sides; full throughput of one product per cycle; backpressure supported.

Parameters:
- W, 8, multiplier operand width. Rows and product are 2*W bits; split point at bit W.

Ports:
- CLK  input  1  clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- in_valid  input  1  row pair on row_s/row_c is valid
- in_ready  output  1  stage can accept row pair this cycle
- row_s  input  2*W  sum row from reduction tree
- row_c  input  2*W  carry row from reduction tree, already bit-aligned (no shift applied here)
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*W  row_s + row_c modulo 2^(2W)
- prod_count  output  8  number of products accepted by consumer, wraps 255->0

Behaviour:
- Reset: RESET high asynchronously forces the following, regardless of CLK:
  - out_valid=0, product=0, prod_count=0
  - internal s1_valid=0, s1 registers=0
  - in_ready reads 1 once RESET deasserts
- Stage 1 register, captured on in_valid && in_ready:
  - lo_sum = row_s[W-1:0] + row_c[W-1:0], W bits
  - lo_carry = carry-out of that W-bit add
  - hi_s = row_s[2W-1:W], hi_c = row_c[2W-1:W]
  - s1_valid set
- Stage 2 (output register), loaded when s1_valid && advance:
  - product = {hi_s + hi_c + lo_carry, lo_sum}; the carry out of bit 2W-1 is discarded
  - out_valid set
- Control equations:
  - advance = !out_valid || out_ready
  - in_ready = !s1_valid || advance, purely combinational from registered state and out_ready
- Latency: the product appears with out_valid=1 on the second rising edge after the input handshake, provided there is no backpressure.
- Output holds: while out_valid && !out_ready, product and out_valid stay stable and stage 1 holds its contents. in_ready=0 if stage 1 is full.
- out_valid drops: when out_ready=1 and s1_valid=0, out_valid clears on the next edge.
- Simultaneous events: input accept and output accept in the same cycle both occur; the pipeline shifts with no bubble.
- prod_count increments on every out_valid && out_ready edge; 255 wraps to 0.
- Reset mid-operation: in-flight data in both stages is discarded; no partial product is emitted after reset.
- No combinational path from in_valid/row_* to any output.

Optional Feature:
- Macro DADDA_CPA_STATUS_EN.
- Defined:
  - adds outputs prod_zero (1 bit) and prod_hi_nz (1 bit), registered alongside product in stage 2
  - prod_zero = (product==0); prod_hi_nz = |product[2W-1:W]
  - both reset to 0 and hold under backpressure like product
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold RESET for 3 cycles, then assert it asynchronously mid-stream with 2 items in flight -> out_valid=0, product=0, prod_count=0 immediately; no stale output after release.
- Carry across split: W=8, row_s=0x00FF, row_c=0x0001, out_ready=1 -> product=0x0100 two edges after accept.
- Wrap and full range: row_s=0xFFFF, row_c=0x0001 -> product=0x0000. Also row_s=0x7E01, row_c=0x8000 (255*255 partial rows) -> product=0xFE01.
- Streaming: 20 back-to-back random row pairs, out_ready=1 -> in_ready stays 1; each product equals the modular sum in order; prod_count=20.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 items are accepted, then in_ready=0 and product stays stable. Raising out_ready drains the items in order with no loss or duplication.
- With DADDA_CPA_STATUS_EN:
  - rows 0x0000/0x0000 -> prod_zero=1, prod_hi_nz=0
  - rows 0x00FF/0x0001 -> prod_zero=0, prod_hi_nz=1
